uart_cmd_decode: RTL and testbench

Command-frame controller between `uart_rx` and the SDRAM read/write path. Consumes received bytes (`rx_data` qualified by `po_flag`) and recognises write and read frames. Write payload bytes go to the write FIFO; a completed frame raises a write or read request towards the SDRAM controller under a req/ack handshake. Also detects inter-byte timeouts, unknown headers and bytes arriving while a request is pending.

---
 rtl/uart_cmd_decode.sv | 141 ++++++++++++++
 tb/tb_uart_cmd_decode.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decode.sv
// Command-frame decoder between uart_rx and the SDRAM read/write path.
// Write frames stream payload into the write FIFO; complete frames raise wr_req/rd_req.
module uart_cmd_decode #(
    parameter int         BURST_LEN = 4,
    parameter logic [7:0] HDR_WR    = 8'h55,
    parameter logic [7:0] HDR_RD    = 8'hAA,
    parameter int         TIMEOUT   = 52080
) (
    input  logic       sclk,
    input  logic       s_rst,
    input  logic [7:0] rx_data,
    input  logic       po_flag,
    output logic       wfifo_wr_en,
    output logic [7:0] wfifo_data,
    output logic       wr_req,
    input  logic       wr_ack,
    output logic       rd_req,
    input  logic       rd_ack,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    // state | meaning
    // IDLE  | waiting for a header byte
    // WDATA | collecting write payload, inter-byte timeout armed
    // WREQ  | write burst requested, waiting for wr_ack
    // RREQ  | read burst requested, waiting for rd_ack
    typedef enum logic [1:0] {IDLE, WDATA, WREQ, RREQ} state_t;

    localparam logic [7:0]  LAST_BYTE = 8'(BURST_LEN - 1);
    localparam logic [15:0] TO_TC     = 16'(TIMEOUT - 1);

    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_HEADER  = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    state_t      state, state_nxt;
    logic [7:0]  byte_cnt, byte_cnt_nxt;
    logic [15:0] to_cnt, to_cnt_nxt;
    logic        wr_en_nxt;
    logic [7:0]  data_nxt;
    logic        err_nxt;
    logic [1:0]  code_nxt;

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        to_cnt_nxt   = to_cnt;
        wr_en_nxt    = 1'b0;
        data_nxt     = wfifo_data;
        err_nxt      = 1'b0;
        code_nxt     = err_code;

        case (state)
            IDLE: begin
                if (po_flag) begin
                    if (rx_data == HDR_WR) begin
                        state_nxt    = WDATA;
                        byte_cnt_nxt = 8'd0;
                        to_cnt_nxt   = 16'd0;
                    end else if (rx_data == HDR_RD) begin
                        state_nxt = RREQ;
                    end else begin
                        err_nxt  = 1'b1;
                        code_nxt = ERR_HEADER;
                    end
                end
            end
            WDATA: begin
                // a byte arriving on the terminal-count cycle still wins
                if (po_flag) begin
                    wr_en_nxt    = 1'b1;
                    data_nxt     = rx_data;
                    byte_cnt_nxt = byte_cnt + 8'd1;
                    to_cnt_nxt   = 16'd0;
                    if (byte_cnt == LAST_BYTE) begin
                        state_nxt = WREQ;
                    end
                end else if (to_cnt == TO_TC) begin
                    state_nxt  = IDLE;
                    to_cnt_nxt = 16'd0;
                    err_nxt    = 1'b1;
                    code_nxt   = ERR_TIMEOUT;
                end else begin
                    to_cnt_nxt = to_cnt + 16'd1;
                end
            end
            WREQ: begin
                if (wr_ack) begin
                    state_nxt = IDLE;
                end
                if (po_flag) begin
                    err_nxt  = 1'b1;
                    code_nxt = ERR_OVERRUN;
                end
            end
            RREQ: begin
                if (rd_ack) begin
                    state_nxt = IDLE;
                end
                if (po_flag) begin
                    err_nxt  = 1'b1;
                    code_nxt = ERR_OVERRUN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered copies of the next-state decode so requests
    // and busy line up with the state they describe.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state       <= IDLE;
            byte_cnt    <= 8'd0;
            to_cnt      <= 16'd0;
            wfifo_wr_en <= 1'b0;
            wfifo_data  <= 8'd0;
            wr_req      <= 1'b0;
            rd_req      <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'd0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            byte_cnt    <= byte_cnt_nxt;
            to_cnt      <= to_cnt_nxt;
            wfifo_wr_en <= wr_en_nxt;
            wfifo_data  <= data_nxt;
            wr_req      <= (state_nxt == WREQ);
            rd_req      <= (state_nxt == RREQ);
            frame_err   <= err_nxt;
            err_code    <= code_nxt;
            busy        <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_cmd_decode.sv
// Bench for uart_cmd_decode: directed frames plus randomized byte/ack traffic,
// every cycle compared against a frame-level reference model.
module tb_uart_cmd_decode;

    localparam int         BURST_LEN = 4;
    localparam int         TIMEOUT   = 40;
    localparam logic [7:0] HDR_WR    = 8'h55;
    localparam logic [7:0] HDR_RD    = 8'hAA;

    localparam int M_IDLE = 0;
    localparam int M_COLL = 1;
    localparam int M_WRP  = 2;
    localparam int M_RDP  = 3;

    logic       sclk;
    logic       s_rst;
    logic [7:0] rx_data;
    logic       po_flag;
    logic       wfifo_wr_en;
    logic [7:0] wfifo_data;
    logic       wr_req;
    logic       wr_ack;
    logic       rd_req;
    logic       rd_ack;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: frame phase, payload bytes received, silent cycles
    int         m_mode;
    int         m_got;
    int         m_quiet;
    logic       e_wr_en;
    logic [7:0] e_data;
    logic       e_err;
    logic [1:0] e_code;

    uart_cmd_decode #(
        .BURST_LEN(BURST_LEN),
        .HDR_WR   (HDR_WR),
        .HDR_RD   (HDR_RD),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .sclk       (sclk),
        .s_rst      (s_rst),
        .rx_data    (rx_data),
        .po_flag    (po_flag),
        .wfifo_wr_en(wfifo_wr_en),
        .wfifo_data (wfifo_data),
        .wr_req     (wr_req),
        .wr_ack     (wr_ack),
        .rd_req     (rd_req),
        .rd_ack     (rd_ack),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .busy       (busy)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_got   = 0;
        m_quiet = 0;
        e_wr_en = 1'b0;
        e_data  = 8'h00;
        e_err   = 1'b0;
        e_code  = 2'd0;
    endtask

    task automatic model_step(input logic po, input logic [7:0] d, input logic wa, input logic ra);
        e_wr_en = 1'b0;
        e_err   = 1'b0;
        if (m_mode == M_IDLE) begin
            if (po) begin
                if (d == HDR_WR) begin
                    m_mode  = M_COLL;
                    m_got   = 0;
                    m_quiet = 0;
                end else if (d == HDR_RD) begin
                    m_mode = M_RDP;
                end else begin
                    e_err  = 1'b1;
                    e_code = 2'd2;
                end
            end
        end else if (m_mode == M_COLL) begin
            if (po) begin
                e_wr_en = 1'b1;
                e_data  = d;
                m_got++;
                m_quiet = 0;
                if (m_got == BURST_LEN) m_mode = M_WRP;
            end else begin
                m_quiet++;
                if (m_quiet == TIMEOUT) begin
                    m_mode = M_IDLE;
                    e_err  = 1'b1;
                    e_code = 2'd1;
                end
            end
        end else begin
            if ((m_mode == M_WRP && wa) || (m_mode == M_RDP && ra)) m_mode = M_IDLE;
            if (po) begin
                e_err  = 1'b1;
                e_code = 2'd3;
            end
        end
    endtask

    task automatic check_outputs();
        chk("wfifo_wr_en", wfifo_wr_en, e_wr_en);
        if (e_wr_en) chk("wfifo_data", wfifo_data, e_data);
        chk("wr_req", wr_req, m_mode == M_WRP);
        chk("rd_req", rd_req, m_mode == M_RDP);
        chk("frame_err", frame_err, e_err);
        chk("err_code", err_code, e_code);
        chk("busy", busy, m_mode != M_IDLE);
    endtask

    task automatic cyc(input logic po, input logic [7:0] d, input logic wa, input logic ra);
        po_flag = po;
        rx_data = d;
        wr_ack  = wa;
        rd_ack  = ra;
        @(posedge sclk);
        model_step(po, d, wa, ra);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        cyc(1'b1, d, 1'b0, 1'b0);
        idle(gap);
    endtask

    // asserted mid-cycle: outputs must clear without waiting for an edge
    task automatic async_reset();
        #3;
        s_rst = 1'b1;
        #1;
        chk("rst_wr_en", wfifo_wr_en, 1'b0);
        chk("rst_wr_req", wr_req, 1'b0);
        chk("rst_rd_req", rd_req, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_err_code", err_code, 2'd0);
        chk("rst_busy", busy, 1'b0);
        model_reset();
        @(posedge sclk);
        #1;
        s_rst = 1'b0;
    endtask

    initial begin
        int cnt;
        int seen;
        int p_div;

        s_rst   = 1'b1;
        po_flag = 1'b0;
        rx_data = 8'h00;
        wr_ack  = 1'b0;
        rd_ack  = 1'b0;
        model_reset();
        #12;
        check_outputs();
        @(posedge sclk);
        #1;
        s_rst = 1'b0;

        // write frame, ack 10 cycles after wr_req rises
        cnt = 0;
        cyc(1'b1, HDR_WR, 1'b0, 1'b0);
        chk("wr_hdr_busy", busy, 1'b1);
        for (int i = 0; i < BURST_LEN; i++) begin
            cyc(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
            if (wfifo_wr_en) cnt++;
            if (i < BURST_LEN - 1) idle(20);
        end
        chk("wr_req_with_last", wr_req, 1'b1);
        idle(9);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wr_req_after_ack", wr_req, 1'b0);
        chk("wr_pulse_count", cnt, BURST_LEN);
        chk("wr_err_code", err_code, 2'd0);

        // read frame, ack held off for 100 cycles
        cnt = 0;
        cyc(1'b1, HDR_RD, 1'b0, 1'b0);
        if (rd_req) cnt++;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
            if (rd_req) cnt++;
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("rd_req_cycles", cnt, 101);
        chk("rd_busy_after_ack", busy, 1'b0);

        // bad header
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("bad_hdr_err", frame_err, 1'b1);
        chk("bad_hdr_code", err_code, 2'd2);
        idle(2);

        // timeout after 55,11 then silence; AA afterwards is a read
        send(HDR_WR, 5);
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        seen = -1;
        for (int i = 1; i <= TIMEOUT + 3; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
            if (frame_err && seen < 0) seen = i;
        end
        chk("timeout_at", seen, TIMEOUT);
        chk("timeout_code", err_code, 2'd1);
        cyc(1'b1, HDR_RD, 1'b0, 1'b0);
        chk("rd_after_timeout", rd_req, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // byte on the terminal-count cycle keeps the frame alive
        cyc(1'b1, HDR_WR, 1'b0, 1'b0);
        idle(TIMEOUT - 1);
        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("tc_byte_wins", frame_err, 1'b0);
        for (int i = 1; i < BURST_LEN; i++) send(8'(i), 3);

        // overrun in the same cycle as wr_ack
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        chk("ovr_wr_req", wr_req, 1'b0);
        chk("ovr_no_write", wfifo_wr_en, 1'b0);
        chk("ovr_code", err_code, 2'd3);
        idle(2);

        // reset mid-frame, then a full frame
        send(HDR_WR, 3);
        send(8'h11, 3);
        async_reset();
        send(HDR_WR, 2);
        for (int i = 0; i < BURST_LEN; i++) send(8'($urandom), 1);
        chk("post_rst_wr_req", wr_req, 1'b1);
        idle(4);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // randomized traffic with varying byte density
        p_div = 2;
        for (int i = 0; i < 4000; i++) begin
            logic       po;
            logic [7:0] d;
            int         r;
            if (i % 250 == 0) begin
                r = $urandom_range(0, 2);
                p_div = (r == 0) ? 2 : (r == 1) ? 8 : 60;
            end
            po = ($urandom_range(0, p_div - 1) == 0);
            r  = $urandom_range(0, 9);
            d  = (r < 3) ? HDR_WR : (r < 5) ? HDR_RD : 8'($urandom);
            if ($urandom_range(0, 599) == 0) async_reset();
            else cyc(po, d, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end

        po_flag = 1'b0;
        wr_ack  = 1'b0;
        rd_ack  = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
